// File: rtl/stall_flush_unit.sv
// Pipeline hazard unit: load-use stall, branch flush and multi-cycle MAC
// hold with timeout, plus a saturating count of front-end stall cycles.
module stall_flush_unit #(
  parameter logic [7:0] MAC_TIMEOUT = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ResultSrcE0,
  input  logic [4:0]  RD_E,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic        PCSrcE,
  input  logic        MacOpE,
  input  logic        MacDone,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MacStart,
  output logic        MacBusy,
  output logic        MacError,
  output logic [15:0] StallCount
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    MAC_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mac_error_q, mac_error_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic lw_stall;
  logic mac_stall;
  logic mac_release;

  // State, wait counter, sticky error and stall counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mac_error_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mac_error_q <= mac_error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state: enter wait on a MAC op, leave on done or timeout
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mac_error_d = mac_error_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (MacOpE) begin
          state_d    = MAC_WAIT;
          wait_cnt_d = '0;
        end
      end
      MAC_WAIT: begin
        if (mac_release) begin
          state_d = IDLE;
          if (!MacDone) mac_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Outputs: hazard decode, all forced low while reset is held
  always_comb begin
    mac_release = MacDone | (wait_cnt_q == MAC_TIMEOUT);
    lw_stall    = ResultSrcE0 & (RD_E != 5'd0) &
                  ((RD_E == RS1_D) | (RD_E == RS2_D));
    mac_stall   = ((state_q == IDLE) & MacOpE) |
                  ((state_q == MAC_WAIT) & ~mac_release);

    StallF     = rst & (lw_stall | mac_stall);
    StallD     = rst & (lw_stall | mac_stall);
    StallE     = rst & mac_stall;
    FlushM     = rst & mac_stall;
    FlushD     = rst & PCSrcE & ~mac_stall;
    FlushE     = rst & (lw_stall | PCSrcE) & ~mac_stall;
    MacStart   = rst & (state_q == IDLE) & MacOpE;
    MacBusy    = rst & (state_q == MAC_WAIT);
    MacError   = mac_error_q;
    StallCount = stall_cnt_q;
  end

endmodule

// File: tb/tb_stall_flush_unit.sv
// Directed bench for stall_flush_unit with a short MAC timeout of 4.
module tb_stall_flush_unit;

  logic        clk;
  logic        rst;
  logic        ResultSrcE0;
  logic [4:0]  RD_E, RS1_D, RS2_D;
  logic        PCSrcE, MacOpE, MacDone;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic        MacStart, MacBusy, MacError;
  logic [15:0] StallCount;

  int checks   = 0;
  int failures = 0;

  stall_flush_unit #(.MAC_TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst), .ResultSrcE0(ResultSrcE0),
    .RD_E(RD_E), .RS1_D(RS1_D), .RS2_D(RS2_D),
    .PCSrcE(PCSrcE), .MacOpE(MacOpE), .MacDone(MacDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MacStart(MacStart), .MacBusy(MacBusy), .MacError(MacError),
    .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ResultSrcE0 = 1'b0; RD_E = 5'd0; RS1_D = 5'd0; RS2_D = 5'd0;
    PCSrcE = 1'b0; MacOpE = 1'b0; MacDone = 1'b0;
  endtask

  function automatic logic [5:0] ctl();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  endfunction

  initial begin
    // Reset held with every hazard input active
    rst = 1'b0;
    ResultSrcE0 = 1'b1; RD_E = 5'd5; RS1_D = 5'd5; RS2_D = 5'd5;
    PCSrcE = 1'b1; MacOpE = 1'b1; MacDone = 1'b1;
    #2;
    check("rst_ctl", 32'(ctl()), 32'd0);
    check("rst_macstart", 32'(MacStart), 32'd0);
    check("rst_macbusy", 32'(MacBusy), 32'd0);
    check("rst_macerror", 32'(MacError), 32'd0);
    check("rst_count", 32'(StallCount), 32'd0);
    tick();
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();

    // Load-use on RS2
    ResultSrcE0 = 1'b1; RD_E = 5'd5; RS1_D = 5'd3; RS2_D = 5'd5;
    #1;
    check("lu_ctl", 32'(ctl()), 32'b110_010);
    tick();
    clear_inputs();
    #1;
    check("lu_count", 32'(StallCount), 32'd1);

    // Load into x0 matching a source register: no hazard
    ResultSrcE0 = 1'b1; RD_E = 5'd0; RS1_D = 5'd0; RS2_D = 5'd7;
    #1;
    check("x0_ctl", 32'(ctl()), 32'd0);
    tick();
    clear_inputs();

    // Taken branch in IDLE
    PCSrcE = 1'b1;
    #1;
    check("br_ctl", 32'(ctl()), 32'b000_110);
    tick();
    clear_inputs();
    #1;
    check("br_count", 32'(StallCount), 32'd1);

    // MAC op completing after 3 wait cycles; branch + load-use mid-wait
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      MacOpE  = 1'b1;
      MacDone = (c == 4);
      if (c == 2) begin
        PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RD_E = 5'd9; RS1_D = 5'd9;
      end
      #1;
      check($sformatf("mac_start_c%0d", c), 32'(MacStart), 32'(c == 0));
      check($sformatf("mac_busy_c%0d", c), 32'(MacBusy), 32'(c >= 1));
      check($sformatf("mac_ctl_c%0d", c), 32'(ctl()), (c < 4) ? 32'b111_001 : 32'd0);
      tick();
    end
    clear_inputs();
    #1;
    check("mac_idle_busy", 32'(MacBusy), 32'd0);
    check("mac_error", 32'(MacError), 32'd0);
    check("mac_count", 32'(StallCount), 32'd5);

    // Timeout: MacDone never arrives, release when wait_cnt reaches 4
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      MacOpE = 1'b1;
      #1;
      check($sformatf("to_stalle_c%0d", c), 32'(StallE), 32'(c < 5));
      check($sformatf("to_busy_c%0d", c), 32'(MacBusy), 32'(c >= 1));
      check($sformatf("to_err_c%0d", c), 32'(MacError), 32'd0);
      tick();
    end
    clear_inputs();
    #1;
    check("to_idle_busy", 32'(MacBusy), 32'd0);
    check("to_error_set", 32'(MacError), 32'd1);
    check("to_count", 32'(StallCount), 32'd10);
    tick();
    tick();
    check("to_error_sticky", 32'(MacError), 32'd1);

    // Reset asserted mid-wait
    MacOpE = 1'b1;
    tick();
    #1;
    check("rw_busy_before", 32'(MacBusy), 32'd1);
    rst = 1'b0;
    #1;
    check("rw_busy", 32'(MacBusy), 32'd0);
    check("rw_ctl", 32'(ctl()), 32'd0);
    check("rw_start", 32'(MacStart), 32'd0);
    check("rw_error", 32'(MacError), 32'd0);
    check("rw_count", 32'(StallCount), 32'd0);
    tick();
    MacOpE = 1'b0;
    rst = 1'b1;
    #1;
    check("rw_after_busy", 32'(MacBusy), 32'd0);
    tick();
    MacOpE = 1'b1;
    #1;
    check("rw_restart", 32'(MacStart), 32'd1);
    tick();
    MacDone = 1'b1;
    #1;
    check("rw_release_stall", 32'(StallF), 32'd0);
    check("rw_release_busy", 32'(MacBusy), 32'd1);
    tick();
    clear_inputs();
    #1;
    check("rw_final_error", 32'(MacError), 32'd0);
    check("rw_final_count", 32'(StallCount), 32'd1);

    // Saturation: continuous load-use stall
    ResultSrcE0 = 1'b1; RD_E = 5'd5; RS1_D = 5'd5;
    for (int i = 0; i < 65533; i++) tick();
    check("sat_fffe", 32'(StallCount), 32'h0000_FFFE);
    tick();
    check("sat_ffff", 32'(StallCount), 32'h0000_FFFF);
    for (int i = 0; i < 4466; i++) tick();
    check("sat_hold", 32'(StallCount), 32'h0000_FFFF);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stall_flush_unit.md
STALL_FLUSH_UNIT -- requirements
Module: stall_flush_unit

Interface
REQ-001 SHALL have parameter MAC_TIMEOUT, default 8'd200, the maximum wait-counter value before a MAC wait is abandoned.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port ResultSrcE0, input, 1 bit: the instruction in E is a load.
REQ-005 SHALL have ports RD_E, RS1_D and RS2_D, inputs, 5 bits each: E destination register and D source registers.
REQ-006 SHALL have port PCSrcE, input, 1 bit: a taken branch or jump is resolved in E.
REQ-007 SHALL have port MacOpE, input, 1 bit: the instruction in E is a multi-cycle MAC op.
REQ-008 SHALL have port MacDone, input, 1 bit: MAC unit completion strobe.
REQ-009 SHALL have ports StallF, StallD and StallE, outputs, 1 bit each: hold the F, D and E pipeline registers.
REQ-010 SHALL have ports FlushD, FlushE and FlushM, outputs, 1 bit each: insert a bubble into D, E or M.
REQ-011 SHALL have port MacStart, output, 1 bit: one-cycle start pulse to the MAC unit.
REQ-012 SHALL have port MacBusy, output, 1 bit: high while the FSM is in MAC_WAIT.
REQ-013 SHALL have port MacError, output, 1 bit: sticky MAC timeout flag.
REQ-014 SHALL have port StallCount, output, 16 bits: saturating count of cycles in which StallF=1.

Function
REQ-015 SHALL implement FSM states IDLE and MAC_WAIT, plus an 8-bit wait_cnt.
REQ-016 SHALL define lwStall = ResultSrcE0 & (RD_E!=0) & ((RD_E==RS1_D)|(RD_E==RS2_D)), combinational.
REQ-017 SHALL define macStall = (IDLE & MacOpE) | (MAC_WAIT & !release), where release = MacDone | (wait_cnt==MAC_TIMEOUT).
REQ-018 SHALL drive MacStart = IDLE & MacOpE, combinational, so it is one cycle per MAC op.
REQ-019 SHALL transition IDLE->MAC_WAIT on the edge when MacOpE=1 and clear wait_cnt to 0 on that edge.
REQ-020 SHALL ignore MacDone in IDLE.
REQ-021 SHALL, in MAC_WAIT without release, increment wait_cnt each cycle.
REQ-022 SHALL, in MAC_WAIT with release, return to IDLE on the next edge.
REQ-023 SHALL, during the release cycle, deassert macStall so the MAC op leaves E on that edge.
REQ-024 SHALL set MacError on a release edge where MacDone=0 (timeout); MacError clears only by reset.
REQ-025 SHALL drive StallF = StallD = lwStall | macStall.
REQ-026 SHALL drive StallE = FlushM = macStall.
REQ-027 SHALL drive FlushD = PCSrcE & !macStall.
REQ-028 SHALL drive FlushE = (lwStall | PCSrcE) & !macStall, so E is never flushed while it is held.
REQ-029 SHALL drive MacBusy = (state==MAC_WAIT), combinational.
REQ-030 SHALL increment StallCount on each edge where StallF=1 and hold it at 16'hFFFF once saturated.
REQ-031 SHALL give a MAC op in E a minimum occupancy of 2 cycles (start and release) and a maximum of MAC_TIMEOUT+2 cycles.
REQ-032 SHALL suppress lwStall when RD_E=0, e.g. a load into x0.

Reset
REQ-033 SHALL, while rst=0, force state=IDLE, wait_cnt=0, MacError=0 and StallCount=0.
REQ-034 SHALL, while rst=0, drive all outputs to 0 regardless of other inputs.
REQ-035 SHALL, on reset assertion in MAC_WAIT, abandon the wait immediately with no MacError.
REQ-036 SHALL, after reset release, assert MacStart only when MacOpE=1 is next observed in IDLE.

Verification
REQ-037 SHALL cover load-use: ResultSrcE0=1, RD_E=5, RS2_D=5 -> StallF=StallD=FlushE=1, StallE=0, StallCount +1.
REQ-038 SHALL cover x0 load: ResultSrcE0=1, RD_E=0, RS1_D=0 -> all stall and flush outputs 0.
REQ-039 SHALL cover a MAC op: MacOpE=1, MacDone after 3 wait cycles -> MacStart for 1 cycle, StallE=FlushM=1 for 4 cycles, MacBusy=1 for 4 cycles, all stalls 0 in the release cycle, MacError=0.
REQ-040 SHALL cover timeout: MAC_TIMEOUT=4, MacDone never -> release when wait_cnt=4, IDLE next edge, MacError=1 and stays 1.
REQ-041 SHALL cover a branch during MAC wait: PCSrcE=1 and lwStall=1 while macStall=1 -> FlushD=FlushE=0; and PCSrcE=1 alone in IDLE -> FlushD=FlushE=1.
REQ-042 SHALL cover reset mid-wait and saturation: rst=0 in MAC_WAIT -> outputs 0, IDLE after release; 70000 stall cycles -> StallCount=16'hFFFF.
